// File: rtl/pk_seq.sv
// pk_seq: two-requester command sequencer in front of the control panel.
// Grants A/B round-robin, turns each command into one-cycle panel strobes,
// holds P0-gated functions until p0, and spaces commands with a quiet gap.
module pk_seq #(
    parameter int GAP_CYCLES = 2,
    parameter int P0_TIMEOUT = 1000000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        a_req,
    input  logic [1:0]  a_cmd,
    input  logic [15:0] a_data,
    output logic        a_ack,
    output logic        a_err,
    input  logic        b_req,
    input  logic [1:0]  b_cmd,
    input  logic [15:0] b_data,
    output logic        b_ack,
    output logic        b_err,
    input  logic        p0,
    output logic [15:0] keys,
    output logic        keys_trig,
    output logic [3:0]  rotary_in,
    output logic        rotary_trig,
    output logic [3:0]  fn,
    output logic        fn_v,
    output logic        fn_trig,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, KEYS, ROT, WAITP0, FN, GAP} state_t;

    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TO_LIMIT = 32'(P0_TIMEOUT);

    state_t      state;
    logic        rr_b;      // 1: next contended grant goes to B
    logic        gnt_b;     // requester owning the command in flight
    logic        loadw_q;   // KEYS phase is followed by a LOAD function
    logic [3:0]  fn_q;      // function code to strobe after WAITP0
    logic        fnv_q;
    logic [31:0] gap_cnt;
    logic [31:0] to_cnt;

    // Data words are numbered bit 0 = MSB, so operand bits 12..15 are the
    // low nibble and operand bit 0 is the top bit of the vector.
    logic        sel_b;
    logic [1:0]  g_cmd;
    logic [15:0] g_data;
    logic        g_gated;

    // Arbitration and operand selection for the IDLE grant
    always_comb begin
        sel_b   = (a_req && b_req) ? rr_b : b_req;
        g_cmd   = sel_b ? b_cmd  : a_cmd;
        g_data  = sel_b ? b_data : a_data;
        g_gated = (g_data[3:0] >= 4'd5) && (g_data[3:0] <= 4'd9);
    end

    // Sequencer: state, registered strobes/acks and held panel values
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_b        <= 1'b0;
            gnt_b       <= 1'b0;
            loadw_q     <= 1'b0;
            fn_q        <= '0;
            fnv_q       <= 1'b0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            keys        <= '0;
            keys_trig   <= 1'b0;
            rotary_in   <= '0;
            rotary_trig <= 1'b0;
            fn          <= '0;
            fn_v        <= 1'b0;
            fn_trig     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            keys_trig   <= 1'b0;
            rotary_trig <= 1'b0;
            fn_trig     <= 1'b0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        busy    <= 1'b1;
                        gnt_b   <= sel_b;
                        to_cnt  <= '0;
                        loadw_q <= (g_cmd == 2'd3);
                        fn_q    <= (g_cmd == 2'd3) ? 4'd8 : g_data[3:0];
                        fnv_q   <= (g_cmd == 2'd3) ? 1'b1 : g_data[15];
                        // pointer moves only when both were asking
                        if (a_req && b_req) rr_b <= ~rr_b;
                        case (g_cmd)
                            2'd0: begin
                                keys      <= g_data;
                                keys_trig <= 1'b1;
                                a_ack     <= ~sel_b;
                                b_ack     <= sel_b;
                                state     <= KEYS;
                            end
                            2'd1: begin
                                rotary_in   <= g_data[3:0];
                                rotary_trig <= 1'b1;
                                a_ack       <= ~sel_b;
                                b_ack       <= sel_b;
                                state       <= ROT;
                            end
                            2'd2: begin
                                if (g_gated) begin
                                    state <= WAITP0;
                                end else begin
                                    fn      <= g_data[3:0];
                                    fn_v    <= g_data[15];
                                    fn_trig <= 1'b1;
                                    a_ack   <= ~sel_b;
                                    b_ack   <= sel_b;
                                    state   <= FN;
                                end
                            end
                            default: begin
                                keys      <= g_data;
                                keys_trig <= 1'b1;
                                state     <= KEYS;
                            end
                        endcase
                    end
                end
                KEYS: begin
                    if (loadw_q) begin
                        to_cnt <= '0;
                        state  <= WAITP0;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                ROT, FN: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                WAITP0: begin
                    if (p0) begin
                        fn      <= fn_q;
                        fn_v    <= fnv_q;
                        fn_trig <= 1'b1;
                        a_ack   <= ~gnt_b;
                        b_ack   <= gnt_b;
                        state   <= FN;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        // abandoned function: the ack/err cycle opens the gap
                        if (TO_LIMIT != 32'd0 && to_cnt + 32'd1 == TO_LIMIT) begin
                            a_ack   <= ~gnt_b;
                            a_err   <= ~gnt_b;
                            b_ack   <= gnt_b;
                            b_err   <= gnt_b;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pk_seq.sv
// tb_pk_seq: directed segments against a transaction-level timeline model.
// Two sequencer instances share stimulus: u0 waits for p0 forever, u1 times
// out after 10 cycles; sel_t picks the one being checked.
module tb_pk_seq;
    localparam int GAP  = 2;
    localparam int NC   = 128;
    localparam int MAXR = 8;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0, p0 = 1'b0;
    logic [1:0]  a_cmd = '0, b_cmd = '0;
    logic [15:0] a_data = '0, b_data = '0;

    logic [1:0]        o_a_ack, o_a_err, o_b_ack, o_b_err;
    logic [1:0]        o_kt, o_rt, o_ft, o_fnv, o_busy;
    logic [1:0][15:0]  o_keys;
    logic [1:0][3:0]   o_rot, o_fn;
    logic              sel_t = 1'b0;

    pk_seq #(.GAP_CYCLES(GAP), .P0_TIMEOUT(0)) u0 (
        .clk_sys(clk_sys), .rst(rst),
        .a_req(a_req), .a_cmd(a_cmd), .a_data(a_data), .a_ack(o_a_ack[0]), .a_err(o_a_err[0]),
        .b_req(b_req), .b_cmd(b_cmd), .b_data(b_data), .b_ack(o_b_ack[0]), .b_err(o_b_err[0]),
        .p0(p0), .keys(o_keys[0]), .keys_trig(o_kt[0]), .rotary_in(o_rot[0]), .rotary_trig(o_rt[0]),
        .fn(o_fn[0]), .fn_v(o_fnv[0]), .fn_trig(o_ft[0]), .busy(o_busy[0]));

    pk_seq #(.GAP_CYCLES(GAP), .P0_TIMEOUT(10)) u1 (
        .clk_sys(clk_sys), .rst(rst),
        .a_req(a_req), .a_cmd(a_cmd), .a_data(a_data), .a_ack(o_a_ack[1]), .a_err(o_a_err[1]),
        .b_req(b_req), .b_cmd(b_cmd), .b_data(b_data), .b_ack(o_b_ack[1]), .b_err(o_b_err[1]),
        .p0(p0), .keys(o_keys[1]), .keys_trig(o_kt[1]), .rotary_in(o_rot[1]), .rotary_trig(o_rt[1]),
        .fn(o_fn[1]), .fn_v(o_fnv[1]), .fn_trig(o_ft[1]), .busy(o_busy[1]));

    // selected instance: {keys_trig,rotary_trig,fn_trig,a_ack,a_err,b_ack,b_err,busy}
    logic [7:0]  ctl;
    logic [15:0] keys_m;
    logic [3:0]  rot_m, fn_m;
    logic        fnv_m;
    always_comb begin
        ctl    = {o_kt[sel_t], o_rt[sel_t], o_ft[sel_t], o_a_ack[sel_t], o_a_err[sel_t],
                  o_b_ack[sel_t], o_b_err[sel_t], o_busy[sel_t]};
        keys_m = o_keys[sel_t];
        rot_m  = o_rot[sel_t];
        fn_m   = o_fn[sel_t];
        fnv_m  = o_fnv[sel_t];
    end

    int n_chk = 0, n_pass = 0;

    function automatic void check(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc %0d: got %h want %h", nm, c, act, exp);
    endfunction

    // ---------------- model: request list + p0 waveform -> timeline --------
    int          nreq;
    int          r_who[MAXR];
    logic [1:0]  r_cmd[MAXR];
    logic [15:0] r_dat[MAXR];
    int          r_arr[MAXR];
    int          r_ack[MAXR];
    bit          p0a[NC];
    int          to_sel;

    bit          e_kt[NC], e_rt[NC], e_ft[NC], e_busy[NC];
    bit          e_ack[2][NC], e_err[2][NC];
    logic [15:0] e_keys[NC];
    logic [3:0]  e_rot[NC], e_fn[NC];
    bit          e_fnv[NC];

    task automatic clear_plan();
        nreq = 0;
        for (int c = 0; c < NC; c++) begin
            p0a[c] = 0; e_kt[c] = 0; e_rt[c] = 0; e_ft[c] = 0; e_busy[c] = 0;
            e_ack[0][c] = 0; e_ack[1][c] = 0; e_err[0][c] = 0; e_err[1][c] = 0;
            e_keys[c] = '0; e_rot[c] = '0; e_fn[c] = '0; e_fnv[c] = 0;
        end
    endtask

    task automatic add_req(int who, logic [1:0] cmd, logic [15:0] d, int arr);
        r_who[nreq] = who; r_cmd[nreq] = cmd; r_dat[nreq] = d;
        r_arr[nreq] = arr; r_ack[nreq] = NC;
        nreq++;
    endtask

    // Gated function from cycle w on: fires the cycle after p0 is seen,
    // or gives up with ack+err after to_sel low cycles.
    task automatic wait_fn(int g, int w, logic [3:0] code, bit v, output int idle);
        idle = NC;
        for (int c = w; c < NC - 2; c++) begin
            if (p0a[c]) begin
                e_ft[c+1] = 1; e_fn[c+1] = code; e_fnv[c+1] = v;
                e_ack[r_who[g]][c+1] = 1; r_ack[g] = c + 1;
                idle = c + 2 + GAP;
                break;
            end
            if (to_sel != 0 && c - w + 1 == to_sel) begin
                e_ack[r_who[g]][c+1] = 1; e_err[r_who[g]][c+1] = 1; r_ack[g] = c + 1;
                idle = c + 1 + GAP;
                break;
            end
        end
    endtask

    task automatic serve(int g, int s, output int idle);
        logic [15:0] d;
        int          who;
        d = r_dat[g]; who = r_who[g];
        idle = s + 2 + GAP;
        case (r_cmd[g])
            2'd0: begin e_kt[s+1] = 1; e_keys[s+1] = d; e_ack[who][s+1] = 1; r_ack[g] = s + 1; end
            2'd1: begin e_rt[s+1] = 1; e_rot[s+1] = d[3:0]; e_ack[who][s+1] = 1; r_ack[g] = s + 1; end
            2'd2: begin
                if (d[3:0] >= 5 && d[3:0] <= 9) wait_fn(g, s + 1, d[3:0], d[15], idle);
                else begin
                    e_ft[s+1] = 1; e_fn[s+1] = d[3:0]; e_fnv[s+1] = d[15];
                    e_ack[who][s+1] = 1; r_ack[g] = s + 1;
                end
            end
            default: begin
                e_kt[s+1] = 1; e_keys[s+1] = d;
                wait_fn(g, s + 2, 4'd8, 1'b1, idle);
            end
        endcase
        for (int c = s + 1; c < idle && c < NC; c++) e_busy[c] = 1;
    endtask

    task automatic plan();
        bit done[MAXR];
        int t, ptr, s, ha, hb, g, idle;
        bit a_ok, b_ok;
        for (int i = 0; i < MAXR; i++) done[i] = 0;
        t = 0; ptr = 0;
        for (int it = 0; it < MAXR; it++) begin
            ha = -1; hb = -1;
            for (int i = 0; i < nreq; i++)
                if (!done[i]) begin
                    if (r_who[i] == 0 && ha < 0) ha = i;
                    if (r_who[i] == 1 && hb < 0) hb = i;
                end
            if (ha < 0 && hb < 0) break;
            s = t;
            if (ha >= 0 && hb >= 0) begin
                if (r_arr[ha] > s && r_arr[hb] > s) s = (r_arr[ha] < r_arr[hb]) ? r_arr[ha] : r_arr[hb];
            end else if (ha >= 0) begin
                if (r_arr[ha] > s) s = r_arr[ha];
            end else if (r_arr[hb] > s) s = r_arr[hb];
            a_ok = (ha >= 0) && (r_arr[ha] <= s);
            b_ok = (hb >= 0) && (r_arr[hb] <= s);
            if (a_ok && b_ok) begin g = ptr ? hb : ha; ptr = 1 - ptr; end
            else g = a_ok ? ha : hb;
            done[g] = 1;
            serve(g, s, idle);
            t = idle;
        end
    endtask

    // requester holds req/cmd/data from arrival through its ack cycle
    task automatic drive(int c);
        a_req = 0; a_cmd = '0; a_data = '0; b_req = 0; b_cmd = '0; b_data = '0;
        for (int i = 0; i < nreq; i++)
            if (r_arr[i] <= c && c <= r_ack[i]) begin
                if (r_who[i] == 0) begin a_req = 1; a_cmd = r_cmd[i]; a_data = r_dat[i]; end
                else begin b_req = 1; b_cmd = r_cmd[i]; b_data = r_dat[i]; end
            end
        p0 = (c < NC) ? p0a[c] : 1'b0;
    endtask

    task automatic check_zero(string nm, int c);
        check({nm, "_ctl"},  c, 32'(ctl), 32'd0);
        check({nm, "_keys"}, c, 32'(keys_m), 32'd0);
        check({nm, "_rot"},  c, 32'(rot_m), 32'd0);
        check({nm, "_fn"},   c, 32'({fn_m, fnv_m}), 32'd0);
    endtask

    int busy_cnt;

    // reset, then compare every cycle against the planned timeline;
    // rst_at >= 0 asserts reset asynchronously mid-cycle there and stops
    task automatic run_seg(int len, int rst_at);
        logic [15:0] m_keys;
        logic [3:0]  m_rot, m_fn;
        bit          m_fnv;
        m_keys = '0; m_rot = '0; m_fn = '0; m_fnv = 0; busy_cnt = 0;
        rst = 1; drive(-1); p0 = 0;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        check_zero("reset", -1);
        @(negedge clk_sys); rst = 0;
        @(posedge clk_sys);
        for (int c = 0; c < len; c++) begin
            #1 drive(c);
            @(negedge clk_sys);
            if (e_kt[c]) m_keys = e_keys[c];
            if (e_rt[c]) m_rot = e_rot[c];
            if (e_ft[c]) begin m_fn = e_fn[c]; m_fnv = e_fnv[c]; end
            if (ctl[0]) busy_cnt++;
            check("ctl",  c, 32'(ctl), 32'({e_kt[c], e_rt[c], e_ft[c], e_ack[0][c], e_err[0][c],
                                            e_ack[1][c], e_err[1][c], e_busy[c]}));
            check("keys", c, 32'(keys_m), 32'(m_keys));
            check("rot",  c, 32'(rot_m), 32'(m_rot));
            check("fn",   c, 32'({fn_m, fnv_m}), 32'({m_fn, m_fnv}));
            if (c == rst_at) begin
                #2 rst = 1;
                #1 check_zero("arst", c);
                break;
            end
            @(posedge clk_sys);
        end
    endtask

    initial begin
        // S1: single KEYS from A
        sel_t = 0; to_sel = 0; clear_plan();
        add_req(0, 2'd0, 16'hA5C3, 2);
        plan();
        check("pin_keys_ack", 0, 32'(r_ack[0]), 32'd3);
        run_seg(12, -1);
        check("busy_len", 0, 32'(busy_cnt), 32'(1 + GAP));

        // S2: contended ROT pairs, round-robin A then B first
        clear_plan();
        add_req(0, 2'd1, 16'h0003, 1);
        add_req(1, 2'd1, 16'h0007, 1);
        add_req(0, 2'd1, 16'h0005, 10);
        add_req(1, 2'd1, 16'h0009, 10);
        plan();
        check("pin_rr_a1", 0, 32'(r_ack[0]), 32'd2);
        check("pin_rr_b1", 0, 32'(r_ack[1]), 32'd6);
        check("pin_rr_b2", 0, 32'(r_ack[3]), 32'd11);
        check("pin_rr_a2", 0, 32'(r_ack[2]), 32'd15);
        run_seg(22, -1);

        // S3: two STOPN presses from B, ungated so p0 stays low
        clear_plan();
        add_req(1, 2'd2, 16'h8003, 1);
        add_req(1, 2'd2, 16'h8003, 4);
        plan();
        check("pin_stopn1", 0, 32'(r_ack[0]), 32'd2);
        check("pin_stopn2", 0, 32'(r_ack[1]), 32'd6);
        run_seg(12, -1);

        // S4: FETCH held 20 cycles until p0 rises, no timeout
        clear_plan();
        for (int c = 22; c < NC; c++) p0a[c] = 1;
        add_req(0, 2'd2, 16'h8005, 1);
        plan();
        check("pin_fetch", 0, 32'(r_ack[0]), 32'd23);
        run_seg(30, -1);

        // S5: FETCH timing out after 10 cycles, then B KEYS after the gap
        sel_t = 1; to_sel = 10; clear_plan();
        add_req(0, 2'd2, 16'h8005, 1);
        add_req(1, 2'd0, 16'h0F0F, 3);
        plan();
        check("pin_timeout", 0, 32'(r_ack[0]), 32'd12);
        check("pin_after_to", 0, 32'(r_ack[1]), 32'd15);
        run_seg(22, -1);

        // S6: LOADW with p0 high
        sel_t = 0; to_sel = 0; clear_plan();
        for (int c = 0; c < NC; c++) p0a[c] = 1;
        add_req(0, 2'd3, 16'h1234, 1);
        plan();
        check("pin_loadw", 0, 32'(r_ack[0]), 32'd4);
        run_seg(12, -1);

        // S7: reset while B's CYCLE function waits for p0
        clear_plan();
        add_req(0, 2'd0, 16'hBEEF, 1);
        add_req(1, 2'd2, 16'h8007, 2);
        plan();
        check("pin_pre_rst", 0, 32'(r_ack[0]), 32'd2);
        run_seg(20, 9);

        // S8: pending B request served after reset release
        clear_plan();
        add_req(1, 2'd0, 16'h00FF, 0);
        plan();
        check("pin_post_rst", 0, 32'(r_ack[0]), 32'd1);
        run_seg(8, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
